// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode encodings for the universal flip-flop bank
package ff_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_JK = 2'b00;
  localparam logic [MODE_W-1:0] MODE_D  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_T  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_SR = 2'b11;

endpackage

// File: rtl/univ_ff_next.sv
// rtl/univ_ff_next.sv - single-bit next-state and SR-conflict logic
import ff_pkg::*;

module univ_ff_next (
  input  logic [MODE_W-1:0] mode,
  input  logic              j,
  input  logic              k,
  input  logic              q,
  output logic              q_next,
  output logic              conflict
);

  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = j;
      MODE_T:  q_next = q ^ j;
      MODE_SR: begin
        // S=R=1 is illegal: hold the bit and report it instead of picking a winner
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   conflict = 1'b1;
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_ff_bank.sv
// rtl/univ_ff_bank.sv - WIDTH-bit JK/D/T/SR flip-flop bank with conflict flags and change counter
import ff_pkg::*;

module univ_ff_bank #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  J,
  input  logic [WIDTH-1:0]  K,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qn,
  output logic              sr_err,
  output logic [WIDTH-1:0]  err_mask,
  output logic [CNT_W-1:0]  chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_sr_err;
  logic [WIDTH-1:0] r_err_mask;
  logic [CNT_W-1:0] r_chg_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conflict;
  logic             w_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_ff_next u_next (
      .mode     (mode),
      .j        (J[i]),
      .k        (K[i]),
      .q        (r_q[i]),
      .q_next   (w_q_next[i]),
      .conflict (w_conflict[i])
    );
  end

  assign w_changed = (w_q_next != r_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= RESET_VAL;
      r_sr_err   <= 1'b0;
      r_err_mask <= '0;
      r_chg_cnt  <= '0;
    end else if (en) begin
      r_q <= w_q_next;
      // a conflict on the clearing edge survives the clear
      if (clr_err) begin
        r_err_mask <= w_conflict;
        r_sr_err   <= |w_conflict;
      end else begin
        r_err_mask <= r_err_mask | w_conflict;
        r_sr_err   <= r_sr_err | (|w_conflict);
      end
      if (w_changed && (r_chg_cnt != CNT_MAX)) begin
        r_chg_cnt <= r_chg_cnt + 1'b1;
      end
    end
  end

  assign Q        = r_q;
  assign Qn       = ~r_q;
  assign sr_err   = r_sr_err;
  assign err_mask = r_err_mask;
  assign chg_cnt  = r_chg_cnt;

endmodule

// File: tb/tb_univ_ff_bank.sv
// tb/tb_univ_ff_bank.sv - directed plus randomized checks of univ_ff_bank against a reference model
module tb_univ_ff_bank;

  localparam int W     = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] J = '0;
  logic [W-1:0] K = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] Q;
  logic [W-1:0] Qn;
  logic         sr_err;
  logic [W-1:0] err_mask;
  logic [CNT_W-1:0] chg_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int m_q    = 0;
  int m_err  = 0;
  int m_mask = 0;
  int m_cnt  = 0;

  univ_ff_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .J        (J),
    .K        (K),
    .clr_err  (clr_err),
    .Q        (Q),
    .Qn       (Qn),
    .sr_err   (sr_err),
    .err_mask (err_mask),
    .chg_cnt  (chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each bit follows the textbook truth table of the selected flip-flop type
  task automatic model_edge(input bit r, input bit e, input int md, input int jv, input int kv, input bit c);
    int nq, conf;
    if (r) begin
      m_q = 0; m_err = 0; m_mask = 0; m_cnt = 0;
      return;
    end
    if (!e) return;
    nq = 0; conf = 0;
    for (int i = 0; i < W; i++) begin
      int qb, jb, kb, nb;
      qb = (m_q >> i) & 1; jb = (jv >> i) & 1; kb = (kv >> i) & 1;
      nb = qb;
      if (md == 1) nb = jb;
      else if (md == 2) nb = qb ^ jb;
      else if (jb == 1 && kb == 0) nb = 1;
      else if (jb == 0 && kb == 1) nb = 0;
      else if (jb == 1 && kb == 1) begin
        if (md == 0) nb = 1 - qb;
        else conf += (1 << i);
      end
      nq += nb << i;
    end
    m_mask = c ? conf : (m_mask | conf);
    m_err  = (c ? 0 : m_err) | (conf != 0 ? 1 : 0);
    if (nq != m_q && m_cnt < CMAX) m_cnt++;
    m_q = nq;
  endtask

  task automatic step(input bit r, input bit e, input logic [1:0] md,
                      input logic [W-1:0] jv, input logic [W-1:0] kv, input bit c);
    rst = r; en = e; mode = md; J = jv; K = kv; clr_err = c;
    @(posedge clk);
    model_edge(r, e, int'(md), int'(jv), int'(kv), c);
    #1;
    chk("q",        32'(Q),        32'(m_q));
    chk("qn",       32'(Qn),       32'(~m_q & 4'hF));
    chk("sr_err",   32'(sr_err),   32'(m_err));
    chk("err_mask", 32'(err_mask), 32'(m_mask));
    chk("chg_cnt",  32'(chg_cnt),  32'(m_cnt));
  endtask

  initial begin
    // reset, with J all ones to prove rst dominates
    step(1, 1, 2'b00, 4'hF, 4'h0, 0);
    step(1, 1, 2'b00, 4'hF, 4'h0, 0);
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_qn", 32'(Qn), 32'hF);
    chk("rst_cnt", 32'(chg_cnt), 32'h0);

    // JK sequence
    step(0, 1, 2'b00, 4'hF, 4'h0, 0); chk("jk_set", 32'(Q), 32'hF);
    step(0, 1, 2'b00, 4'h0, 4'h0, 0); chk("jk_hold", 32'(Q), 32'hF);
    chk("jk_hold_cnt", 32'(chg_cnt), 32'd1);
    step(0, 1, 2'b00, 4'h0, 4'h5, 0); chk("jk_reset", 32'(Q), 32'hA);
    step(0, 1, 2'b00, 4'hF, 4'hF, 0); chk("jk_tog1", 32'(Q), 32'h5);
    step(0, 1, 2'b00, 4'hF, 4'hF, 0); chk("jk_tog2", 32'(Q), 32'hA);
    chk("jk_cnt", 32'(chg_cnt), 32'd4);

    // D, T, then disabled edge
    step(0, 1, 2'b01, 4'h3, 4'hC, 0); chk("d_mode", 32'(Q), 32'h3);
    step(0, 1, 2'b10, 4'h6, 4'hF, 0); chk("t_mode", 32'(Q), 32'h5);
    step(0, 0, 2'b01, 4'hF, 4'h0, 1); chk("en0_q", 32'(Q), 32'h5);
    chk("en0_cnt", 32'(chg_cnt), 32'd6);

    // mid-run reset from 1010
    step(0, 1, 2'b01, 4'hA, 4'h0, 0); chk("pre_rst", 32'(Q), 32'hA);
    step(1, 1, 2'b10, 4'hF, 4'hF, 1); chk("mid_rst", 32'(Q), 32'h0);

    // SR conflicts and clearing
    step(0, 1, 2'b11, 4'hC, 4'h6, 0);
    chk("sr_q", 32'(Q), 32'h8);
    chk("sr_mask", 32'(err_mask), 32'h4);
    chk("sr_err", 32'(sr_err), 32'h1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 0); chk("sr_sticky", 32'(err_mask), 32'h4);
    step(0, 1, 2'b11, 4'h0, 4'h0, 1); chk("sr_clr", 32'(sr_err), 32'h0);
    step(0, 1, 2'b11, 4'h1, 4'h1, 1);
    chk("sr_setwins_mask", 32'(err_mask), 32'h1);
    chk("sr_setwins_err", 32'(sr_err), 32'h1);
    chk("sr_setwins_q", 32'(Q), 32'h8);

    // counter saturation
    step(1, 1, 2'b00, 4'h0, 4'h0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 2'b10, 4'h1, 4'h0, 0);
      chk("sat_cnt", 32'(chg_cnt), 32'(i < CMAX ? i : CMAX));
    end
    step(1, 1, 2'b10, 4'h1, 4'h0, 0); chk("sat_rst", 32'(chg_cnt), 32'h0);

    // JK toggle with clr_err, then back-to-back mode switch
    step(0, 1, 2'b00, 4'hF, 4'hF, 1);
    chk("jk_clr_q", 32'(Q), 32'hF);
    chk("jk_clr_err", 32'(sr_err), 32'h0);
    chk("jk_clr_mask", 32'(err_mask), 32'h0);
    step(0, 1, 2'b01, 4'h3, 4'h0, 0); chk("sw_d", 32'(Q), 32'h3);
    step(0, 1, 2'b10, 4'h1, 4'h0, 0); chk("sw_t", 32'(Q), 32'h2);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
